ysyx_25030077_ifu: RTL and testbench

Instruction fetch unit for the single-issue ysyx_25030077 core. Owns the architectural PC register, fetches one instruction at a time from instruction memory over a request/response handshake, and presents the fetched instruction together with its PC to decode/execute. It sits directly upstream of the next-PC stage. `io_instruction` and `io_pc_count` feed that stage, and its `io_pc_next` and `io_is_unknown_instruction` come back here to update the PC at retire.

---
 rtl/ysyx_25030077_ifu_pkg.sv | 15 +
 rtl/ysyx_25030077_ifu.sv | 102 ++++++++++
 tb/tb_ysyx_25030077_ifu.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25030077_ifu_pkg.sv
// Shared types and constants for the ysyx_25030077 instruction fetch unit.
package ysyx_25030077_ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/ysyx_25030077_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, halts on faults.
// Optional: YSYX_25030077_IFU_MISALIGN_CHECK_EN halts on a misaligned next PC.
module ysyx_25030077_ifu
  import ysyx_25030077_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       io_pc_next,
  input  logic              io_is_unknown_instruction,
  output logic              io_imem_req_valid,
  input  logic              io_imem_req_ready,
  output logic [31:0]       io_imem_req_addr,
  input  logic              io_imem_resp_valid,
  input  logic [INST_W-1:0] io_imem_resp_data,
  input  logic              io_imem_resp_err,
  output logic              io_inst_valid,
  input  logic              io_inst_ready,
  output logic [INST_W-1:0] io_instruction,
  output logic [31:0]       io_pc_count,
  output logic [31:0]       io_retired,
  output logic              io_halted,
  output logic              io_fault
);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       retired_q, retired_d;
  logic              fault_q, fault_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (io_imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (io_imem_resp_valid) begin
          if (io_imem_resp_err) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            inst_d  = io_imem_resp_data;
            state_d = ST_VALID;
          end
        end
      end
      ST_VALID: begin
        if (io_inst_ready) begin
          if (io_is_unknown_instruction) begin
            state_d = ST_HALT;
`ifdef YSYX_25030077_IFU_MISALIGN_CHECK_EN
          end else if (io_pc_next[1:0] != 2'b00) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
`endif
          end else begin
            pc_d      = io_pc_next;
            retired_d = retired_q + 32'd1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Valids decode straight from the state register.
  assign io_imem_req_valid = (state_q == ST_REQ);
  assign io_inst_valid     = (state_q == ST_VALID);
  assign io_halted         = (state_q == ST_HALT);
  assign io_imem_req_addr  = pc_q;
  assign io_pc_count       = pc_q;
  assign io_instruction    = inst_q;
  assign io_retired        = retired_q;
  assign io_fault          = fault_q;

endmodule

// File: tb/tb_ysyx_25030077_ifu.sv
// Directed self-checking bench for ysyx_25030077_ifu.
module tb_ysyx_25030077_ifu;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        unknown;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc_count;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  int total = 0;
  int bad = 0;

  ysyx_25030077_ifu dut (
    .clock                     (clock),
    .reset                     (reset),
    .io_pc_next                (pc_next),
    .io_is_unknown_instruction (unknown),
    .io_imem_req_valid         (req_valid),
    .io_imem_req_ready         (req_ready),
    .io_imem_req_addr          (req_addr),
    .io_imem_resp_valid        (resp_valid),
    .io_imem_resp_data         (resp_data),
    .io_imem_resp_err          (resp_err),
    .io_inst_valid             (inst_valid),
    .io_inst_ready             (inst_ready),
    .io_instruction            (instruction),
    .io_pc_count               (pc_count),
    .io_retired                (retired),
    .io_halted                 (halted),
    .io_fault                  (fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in REQ with req_ready=1; ends in VALID.
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] word);
    chk({tag, ".req_valid"}, {31'd0, req_valid}, 32'd1);
    chk({tag, ".req_addr"}, req_addr, addr);
    tick();
    chk({tag, ".wait_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    resp_valid = 1'b1;
    resp_data  = word;
    tick();
    resp_valid = 1'b0;
    resp_data  = 32'hDEAD_BEEF;
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, ".instruction"}, instruction, word);
    chk({tag, ".pc_count"}, pc_count, addr);
  endtask

  task automatic retire(input logic [31:0] nxt, input logic unk);
    inst_ready = 1'b1;
    pc_next    = nxt;
    unknown    = unk;
    tick();
    inst_ready = 1'b0;
    unknown    = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    pc_next    = 32'h0;
    unknown    = 1'b0;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    resp_err   = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    chk("rst.req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.retired", retired, 32'd0);
    chk("rst.pc", pc_count, 32'h8000_0000);
    chk("rst.inst", instruction, 32'd0);

    // Cycle 1 after reset: IDLE; cycle 2: REQ.
    reset = 1'b0;
    chk("c1.req_valid", {31'd0, req_valid}, 32'd0);
    tick();
    fetch("f0", 32'h8000_0000, 32'h0000_0013);
    retire(32'h8000_0004, 1'b0);
    chk("r1.retired", retired, 32'd1);
    fetch("f1", 32'h8000_0004, 32'h0010_0093);
    retire(32'h8000_0008, 1'b0);
    fetch("f2", 32'h8000_0008, 32'h0020_0113);
    retire(32'h8000_000C, 1'b0);
    chk("r3.retired", retired, 32'd3);

    // Stalls; a stray error response in REQ must be ignored.
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_err   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall.req_valid", {31'd0, req_valid}, 32'd1);
      chk("stall.req_addr", req_addr, 32'h8000_000C);
    end
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    chk("stall.fault", {31'd0, fault}, 32'd0);
    req_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall.wait", {31'd0, inst_valid}, 32'd0);
    end
    resp_valid = 1'b1;
    resp_data  = 32'h0030_0193;
    tick();
    resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall.hold_pc", pc_count, 32'h8000_000C);
      chk("stall.hold_inst", instruction, 32'h0030_0193);
    end
    chk("stall.retired_hold", retired, 32'd3);
    retire(32'h8000_0010, 1'b0);
    chk("stall.retired", retired, 32'd4);

    // Self-loop refetches the same address.
    fetch("f4", 32'h8000_0010, 32'h0040_0213);
    retire(32'h8000_0010, 1'b0);
    chk("loop.retired", retired, 32'd5);
    fetch("f5", 32'h8000_0010, 32'hFFFF_FFFF);

    // Unknown instruction.
    retire(32'h0000_1234, 1'b1);
    chk("unk.halted", {31'd0, halted}, 32'd1);
    chk("unk.fault", {31'd0, fault}, 32'd0);
    chk("unk.pc", pc_count, 32'h8000_0010);
    chk("unk.retired", retired, 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("unk.no_req", {31'd0, req_valid}, 32'd0);
      chk("unk.no_inst", {31'd0, inst_valid}, 32'd0);
    end

    // Access fault.
    reset = 1'b1;
    tick();
    chk("rst2.halted", {31'd0, halted}, 32'd0);
    chk("rst2.retired", retired, 32'd0);
    reset = 1'b0;
    tick();
    chk("af.req_addr", req_addr, 32'h8000_0000);
    tick();
    resp_valid = 1'b1;
    resp_err   = 1'b1;
    tick();
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    chk("af.halted", {31'd0, halted}, 32'd1);
    chk("af.fault", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("af.no_inst", {31'd0, inst_valid}, 32'd0);
      tick();
    end

    // Reset mid-WAIT with a response arriving during reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("mw.in_wait", {31'd0, req_valid | inst_valid}, 32'd0);
    reset      = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 32'h1234_5678;
    tick();
    resp_valid = 1'b0;
    reset      = 1'b0;
    chk("mw.inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mw.inst", instruction, 32'd0);
    chk("mw.fault", {31'd0, fault}, 32'd0);
    tick();
    fetch("mw", 32'h8000_0000, 32'h0050_0293);

`ifdef YSYX_25030077_IFU_MISALIGN_CHECK_EN
    retire(32'h8000_0002, 1'b0);
    chk("mis.halted", {31'd0, halted}, 32'd1);
    chk("mis.fault", {31'd0, fault}, 32'd1);
    chk("mis.retired", retired, 32'd0);
    chk("mis.pc", pc_count, 32'h8000_0000);
`else
    retire(32'h8000_0002, 1'b0);
    chk("mis.retired", retired, 32'd1);
    chk("mis.halted", {31'd0, halted}, 32'd0);
    fetch("mis", 32'h8000_0002, 32'h0060_0313);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
